// File: rtl/com_uart_frame_rx.sv
// Frame parser downstream of the UART receiver: SYNC, ADDR, LEN, payload, XOR checksum.
// One validated payload is held in a buffer and read out show-ahead via rd_en/rd_data.
module com_uart_frame_rx #(
  parameter int unsigned               DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]     SYNC_BYTE      = 8'hC0,
  parameter int unsigned               MAX_PAYLOAD    = 32,
  parameter int unsigned               TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_parity_ok,
  output logic                  frame_ready,
  output logic [DATA_WIDTH-1:0] frame_addr,
  output logic [DATA_WIDTH-1:0] frame_len,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  err_chk,
  output logic                  err_len,
  output logic                  err_parity,
  output logic                  err_timeout,
  output logic                  overrun
);

  localparam int unsigned PTR_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int unsigned LEN_W = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DATA_WIDTH:0] LEN_MAX  = (DATA_WIDTH + 1)'(MAX_PAYLOAD);
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state;
  logic [TMO_W-1:0]      r_tmo;
  logic [DATA_WIDTH-1:0] r_chk;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [LEN_W-1:0]      r_len;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_buf [MAX_PAYLOAD];

  logic w_in_frame;
  logic w_tmo_hit;
  logic w_len_bad;
  logic w_wr_last;
  logic w_rd_last;
  logic w_err_chk;
  logic w_err_len;
  logic w_err_par;
  logic w_err_tmo;
  logic w_ovr;
  logic w_addr_we;
  logic w_len_we;
  logic w_buf_we;
  logic w_rd_adv;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_LEN) ||
                      (r_state == S_PAYLOAD) || (r_state == S_CHK);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign w_tmo_hit  = w_in_frame && !rx_valid && (r_tmo == TMO_LAST);
  assign w_len_bad  = (rx_data == '0) || ({1'b0, rx_data} > LEN_MAX);
  assign w_wr_last  = (LEN_W'(r_wr_ptr) == (r_len - LEN_W'(1)));
  assign w_rd_last  = (LEN_W'(r_rd_ptr) == (r_len - LEN_W'(1)));
  assign rd_data    = r_buf[r_rd_ptr];

  always_comb begin
    w_state   = r_state;
    w_err_chk = 1'b0;
    w_err_len = 1'b0;
    w_err_par = 1'b0;
    w_err_tmo = 1'b0;
    w_ovr     = 1'b0;
    w_addr_we = 1'b0;
    w_len_we  = 1'b0;
    w_buf_we  = 1'b0;
    w_rd_adv  = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (rx_valid && rx_parity_ok && (rx_data == SYNC_BYTE)) w_state = S_ADDR;
      end
      S_ADDR, S_LEN, S_PAYLOAD, S_CHK: begin
        if (rx_valid) begin
          if (!rx_parity_ok) begin
            w_err_par = 1'b1;
            w_state   = S_HUNT;
          end else begin
            case (r_state)
              S_ADDR: begin
                w_addr_we = 1'b1;
                w_state   = S_LEN;
              end
              S_LEN: begin
                if (w_len_bad) begin
                  w_err_len = 1'b1;
                  w_state   = S_HUNT;
                end else begin
                  w_len_we = 1'b1;
                  w_state  = S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                w_buf_we = 1'b1;
                if (w_wr_last) w_state = S_CHK;
              end
              default: begin
                if (rx_data == r_chk) begin
                  w_state = S_HOLD;
                end else begin
                  w_err_chk = 1'b1;
                  w_state   = S_HUNT;
                end
              end
            endcase
          end
        end else if (w_tmo_hit) begin
          w_err_tmo = 1'b1;
          w_state   = S_HUNT;
        end
      end
      S_HOLD: begin
        w_ovr = rx_valid;
        if (rd_en) begin
          w_rd_adv = 1'b1;
          if (w_rd_last) w_state = S_HUNT;
        end
      end
      default: w_state = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_tmo       <= '0;
      r_chk       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      frame_ready <= 1'b0;
      frame_addr  <= '0;
      frame_len   <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_parity  <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_state     <= w_state;
      frame_ready <= (w_state == S_HOLD);
      err_chk     <= w_err_chk;
      err_len     <= w_err_len;
      err_parity  <= w_err_par;
      err_timeout <= w_err_tmo;
      overrun     <= w_ovr;

      if (!w_in_frame || rx_valid || w_tmo_hit) r_tmo <= '0;
      else                                       r_tmo <= r_tmo + 1'b1;

      if (w_addr_we) begin
        r_addr <= rx_data;
        r_chk  <= rx_data;
      end
      if (w_len_we) begin
        r_len    <= rx_data[LEN_W-1:0];
        r_chk    <= r_chk ^ rx_data;
        r_wr_ptr <= '0;
      end
      if (w_buf_we) begin
        r_chk    <= r_chk ^ rx_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // Header outputs are published only when a frame validates, so a new
      // frame being parsed never disturbs what the reader last saw.
      if ((w_state == S_HOLD) && (r_state != S_HOLD)) begin
        frame_addr <= r_addr;
        frame_len  <= DATA_WIDTH'(r_len);
        r_rd_ptr   <= '0;
      end else if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_wr_ptr] <= rx_data;
  end

endmodule
